// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller: one anode at a time, hex decode,
// dead-time blanking per slot, and frame-aligned application of buffered updates.
module seg_scan_ctrl #(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 64
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [4*N_DIGITS-1:0]   upd_data,
  input  logic [N_DIGITS-1:0]     upd_dp,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [PW-1:0] P_LAST      = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] P_BLANK_END = PW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ONE_HOT0 = N_DIGITS'(1);

  typedef enum logic [1:0] {S_OFF, S_BLANK, S_DRIVE} state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [IW-1:0] r_idx,   w_idx_nxt;
  logic          w_boundary;

  logic [N_DIGITS-1:0][3:0] r_pend_data, r_act_data;
  logic [N_DIGITS-1:0]      r_pend_dp,   r_act_dp;
  logic                     r_pend_full;
  logic                     w_accept;

  logic [N_DIGITS-1:0] r_an;
  logic [6:0]          r_seg, w_seg_dec;
  logic [3:0]          w_nib;
  logic                r_dp, r_fs;

  // Scan sequencer; en low forces OFF on the next edge from any state.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_idx_nxt   = r_idx;
    w_boundary  = 1'b0;
    if (!en) begin
      w_state_nxt = S_OFF;
      w_presc_nxt = '0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_nxt = S_BLANK;
          w_presc_nxt = '0;
          w_idx_nxt   = '0;
          w_boundary  = 1'b1;
        end
        S_BLANK: begin
          w_presc_nxt = r_presc + 1'b1;
          if (r_presc == P_BLANK_END) w_state_nxt = S_DRIVE;
        end
        S_DRIVE: begin
          if (r_presc == P_LAST) begin
            w_presc_nxt = '0;
            w_state_nxt = S_BLANK;
            if (r_idx == IDX_LAST) begin
              w_idx_nxt  = '0;
              w_boundary = 1'b1;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else begin
            w_presc_nxt = r_presc + 1'b1;
          end
        end
        default: w_state_nxt = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state <= S_OFF;
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Apply and accept are mutually exclusive: accept requires an empty buffer.
  assign w_accept  = upd_valid && !r_pend_full;
  assign upd_ready = ~r_pend_full;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pend_full <= 1'b0;
      r_act_data  <= '0;
      r_act_dp    <= '0;
    end else if (w_boundary && r_pend_full) begin
      r_act_data  <= r_pend_data;
      r_act_dp    <= r_pend_dp;
      r_pend_full <= 1'b0;
    end else if (w_accept) begin
      r_pend_data <= upd_data;
      r_pend_dp   <= upd_dp;
      r_pend_full <= 1'b1;
    end
  end

  assign w_nib = r_act_data[r_idx];

  always_comb begin
    w_seg_dec = 7'h7F;
    case (w_nib)
      4'h0: w_seg_dec = 7'h40;
      4'h1: w_seg_dec = 7'h79;
      4'h2: w_seg_dec = 7'h24;
      4'h3: w_seg_dec = 7'h30;
      4'h4: w_seg_dec = 7'h19;
      4'h5: w_seg_dec = 7'h12;
      4'h6: w_seg_dec = 7'h02;
      4'h7: w_seg_dec = 7'h78;
      4'h8: w_seg_dec = 7'h00;
      4'h9: w_seg_dec = 7'h10;
      4'hA: w_seg_dec = 7'h08;
      4'hB: w_seg_dec = 7'h03;
      4'hC: w_seg_dec = 7'h46;
      4'hD: w_seg_dec = 7'h21;
      4'hE: w_seg_dec = 7'h06;
      4'hF: w_seg_dec = 7'h0E;
      default: w_seg_dec = 7'h7F;
    endcase
  end

  // Display pins are registered off the current state, one cycle behind it.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_an  <= '1;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
      r_fs  <= 1'b0;
    end else begin
      r_fs <= w_boundary;
      if (r_state == S_DRIVE) begin
        r_an  <= ~(ONE_HOT0 << r_idx);
        r_seg <= w_seg_dec;
        r_dp  <= ~r_act_dp[r_idx];
      end else begin
        r_an  <= '1;
        r_seg <= 7'h7F;
        r_dp  <= 1'b1;
      end
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2, N_DIGITS=4 (32-cycle frame).
module tb_seg_scan_ctrl;

  logic        clk_in = 1'b0;
  logic        reset, en, upd_valid, upd_ready, dp, frame_start;
  logic [15:0] upd_data;
  logic [3:0]  upd_dp, an;
  logic [6:0]  seg;

  int n_chk  = 0;
  int n_fail = 0;
  int fk     = 0;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
  } dec_vec_t;
  dec_vec_t vecs[16];

  logic [15:0] fd[5];
  logic [3:0]  fdp[5];

  seg_scan_ctrl #(.N_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk_in(clk_in), .reset(reset), .en(en), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_data(upd_data), .upd_dp(upd_dp), .an(an), .seg(seg), .dp(dp),
    .frame_start(frame_start)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    fk++;
    @(negedge clk_in);
  endtask

  function automatic int fidx(input int k);
    return (k < 2) ? 0 : (k - 2) / 32;
  endfunction

  // k = posedges since the edge that first sampled en=1 out of OFF.
  task automatic chk_cycle(input int k, input logic [15:0] d, input logic [3:0] p);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fs;
    int pp, dig, pr;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    e_fs = (k >= 1) && (((k - 1) % 32) == 0);
    if (k >= 2) begin
      pp  = (k - 2) % 32;
      dig = pp / 8;
      pr  = pp % 8;
      if (pr >= 2) begin
        e_an  = ~(4'b0001 << dig);
        e_seg = vecs[d[dig*4 +: 4]].seg;
        e_dp  = ~p[dig];
      end
    end
    chk($sformatf("an@k%0d", k), 32'(an), 32'(e_an));
    chk($sformatf("seg@k%0d", k), 32'(seg), 32'(e_seg));
    chk($sformatf("dp@k%0d", k), 32'(dp), 32'(e_dp));
    chk($sformatf("frame_start@k%0d", k), 32'(frame_start), 32'(e_fs));
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp"}, 32'(dp), 32'h1);
    chk({tag, "_fs"}, 32'(frame_start), 32'h0);
  endtask

  initial begin
    vecs[0]  = '{4'h0, 7'h40}; vecs[1]  = '{4'h1, 7'h79};
    vecs[2]  = '{4'h2, 7'h24}; vecs[3]  = '{4'h3, 7'h30};
    vecs[4]  = '{4'h4, 7'h19}; vecs[5]  = '{4'h5, 7'h12};
    vecs[6]  = '{4'h6, 7'h02}; vecs[7]  = '{4'h7, 7'h78};
    vecs[8]  = '{4'h8, 7'h00}; vecs[9]  = '{4'h9, 7'h10};
    vecs[10] = '{4'hA, 7'h08}; vecs[11] = '{4'hB, 7'h03};
    vecs[12] = '{4'hC, 7'h46}; vecs[13] = '{4'hD, 7'h21};
    vecs[14] = '{4'hE, 7'h06}; vecs[15] = '{4'hF, 7'h0E};
    fd[0] = 16'h0000; fdp[0] = 4'b0000;
    fd[1] = 16'h1A3F; fdp[1] = 4'b0100;
    fd[2] = 16'hC5E7; fdp[2] = 4'b1001;
    fd[3] = 16'hC5E7; fdp[3] = 4'b1001;
    fd[4] = 16'hC5E7; fdp[4] = 4'b1001;

    reset = 1'b0; en = 1'b0; upd_valid = 1'b0; upd_data = '0; upd_dp = '0;
    repeat (2) @(negedge clk_in);
    chk_dark("reset");
    chk("reset_ready", 32'(upd_ready), 32'h1);

    // Scan, mid-frame update, held valid while not ready
    reset = 1'b1; en = 1'b1; fk = 0;
    for (int k = 1; k <= 150; k++) begin
      tick();
      chk_cycle(fk, fd[fidx(fk)], fdp[fidx(fk)]);
      if (k == 10) begin
        chk("ready_before_accept", 32'(upd_ready), 32'h1);
        upd_valid = 1'b1; upd_data = 16'h1A3F; upd_dp = 4'b0100;
      end
      if (k == 11) begin
        chk("ready_after_accept", 32'(upd_ready), 32'h0);
        upd_valid = 1'b0;
      end
      if (k == 32) chk("ready_before_boundary", 32'(upd_ready), 32'h0);
      if (k == 33) chk("ready_after_boundary", 32'(upd_ready), 32'h1);
      if (k == 40) begin
        upd_valid = 1'b1; upd_data = 16'hC5E7; upd_dp = 4'b1001;
      end
      if (k == 41) begin
        chk("ready_after_accept2", 32'(upd_ready), 32'h0);
        upd_data = 16'h9999; upd_dp = 4'b1111;
      end
      if (k == 59) chk("ready_held_low", 32'(upd_ready), 32'h0);
      if (k == 60) upd_valid = 1'b0;
      if (k == 65) chk("ready_after_boundary2", 32'(upd_ready), 32'h1);
    end

    // en low during digit 2 DRIVE, buffer an update while off, re-enable
    en = 1'b0;
    tick();
    chk("en0_fs", 32'(frame_start), 32'h0);
    chk("ready_while_off", 32'(upd_ready), 32'h1);
    upd_valid = 1'b1; upd_data = 16'h0F0F; upd_dp = 4'b0011;
    tick();
    chk_dark("en0_dark1");
    upd_valid = 1'b0;
    tick();
    chk_dark("en0_dark2");
    chk("ready_pending_off", 32'(upd_ready), 32'h0);

    en = 1'b1; fk = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk_cycle(fk, 16'h0F0F, 4'b0011);
      if (k == 1) chk("ready_after_reenable", 32'(upd_ready), 32'h1);
      if (k == 10) begin
        upd_valid = 1'b1; upd_data = 16'h8888; upd_dp = 4'b1111;
      end
      if (k == 11) begin
        upd_valid = 1'b0;
        chk("ready_pending_w", 32'(upd_ready), 32'h0);
      end
    end

    // Async reset mid-DRIVE with the buffer full
    reset = 1'b0;
    #1;
    chk_dark("async_reset");
    chk("async_reset_ready", 32'(upd_ready), 32'h1);
    @(negedge clk_in);
    reset = 1'b1; fk = 0;
    for (int k = 1; k <= 66; k++) begin
      tick();
      chk_cycle(fk, 16'h0000, 4'b0000);
    end

    // Full decode table on digit 0, each value loaded while off
    for (int i = 0; i < 16; i++) begin
      en = 1'b0; upd_valid = 1'b1; upd_data = {12'h000, vecs[i].nib}; upd_dp = 4'b0000;
      tick();
      upd_valid = 1'b0; en = 1'b1; fk = 0;
      repeat (4) tick();
      chk($sformatf("dec_an_%0h", vecs[i].nib), 32'(an), 32'hE);
      chk($sformatf("dec_seg_%0h", vecs[i].nib), 32'(seg), 32'(vecs[i].seg));
      chk($sformatf("dec_dp_%0h", vecs[i].nib), 32'(dp), 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
